// File: rtl/inst_cache_pkg.sv
// Shared constants for the direct-mapped instruction cache.
// The FSM state encoding is kept as plain localparams so older code can use the same codes.
package inst_cache_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [31:0] ZERO = 32'h0000_0000;

  localparam logic [0:0] ICACHE_IDLE = 1'b0;
  localparam logic [0:0] ICACHE_MISS = 1'b1;

  // A fetch address with its byte-offset bits forced to zero.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_cache_store.sv
// Line storage for inst_cache: a valid bit vector, a tag array and a data array.
// Reads are combinational. There is one write port, used by the miss fill.
module inst_cache_store
  import inst_cache_pkg::*;
#(
  parameter int INDEX_BITS = 8,
  parameter int TAG_W      = 22,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [DATA_W-1:0]     rd_data
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tags  [LINES];
  logic [DATA_W-1:0] words [LINES];

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= '0;
    end else if (rdy && we) begin
      valid[wr_index] <= TRUE;
    end
  end

  // NOTE: the tag and data arrays have no reset. The valid bits alone decide whether a line
  // is live, so the arrays can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (rst && rdy && we) begin
      tags[wr_index]  <= wr_tag;
      words[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_data  = words[rd_index];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped instruction cache with one word per line, placed between the IF stage and the memory controller.
// On a miss it holds a fetch request until the controller returns the word; a flush during the miss suppresses the reply.
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int INDEX_BITS = 8,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic              flush,
  output logic              if_valid,
  output logic [31:0]       if_instr,
  output logic              mc_fet_ena,
  output logic [ADDR_W-1:0] mc_addr,
  input  logic              mc_valid,
  input  logic [31:0]       mc_data
);

  localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

  logic [0:0]            state;
  logic                  discard;
  logic [INDEX_BITS-1:0] miss_index;
  logic [TAG_W-1:0]      miss_tag;

  logic [INDEX_BITS-1:0] pc_index;
  logic [TAG_W-1:0]      pc_tag;
  logic                  line_valid;
  logic [TAG_W-1:0]      line_tag;
  logic [31:0]           line_data;
  logic                  hit;
  logic                  fill;
  logic                  unused_pc_bits;

  assign pc_index       = if_pc[INDEX_BITS+1:2];
  assign pc_tag         = if_pc[ADDR_W-1:INDEX_BITS+2];
  assign hit            = line_valid && (line_tag == pc_tag);
  assign unused_pc_bits = ^if_pc[1:0];

  // A fill only happens for a response that arrives while a miss is open. A stray mc_valid in IDLE writes nothing.
  assign fill = (state == ICACHE_MISS) && mc_valid;

  inst_cache_store #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_W      (TAG_W),
    .DATA_W     (32)
  ) u_store (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .we       (fill),
    .wr_index (miss_index),
    .wr_tag   (miss_tag),
    .wr_data  (mc_data),
    .rd_index (pc_index),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data)
  );

  // NOTE: every register below uses non-blocking assignment, so all decisions in a cycle
  // see the state from before the edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ICACHE_IDLE;
      discard    <= FALSE;
      if_valid   <= FALSE;
      if_instr   <= ZERO;
      mc_fet_ena <= FALSE;
      mc_addr    <= '0;
      miss_index <= '0;
      miss_tag   <= '0;
    end else if (rdy) begin
      if_valid <= FALSE;
      case (state)
        ICACHE_IDLE: begin
          if (if_req && !flush) begin
            if (hit) begin
              if_valid <= TRUE;
              if_instr <= line_data;
            end else begin
              mc_fet_ena <= TRUE;
              mc_addr    <= {if_pc[ADDR_W-1:2], 2'b00};
              miss_index <= pc_index;
              miss_tag   <= pc_tag;
              state      <= ICACHE_MISS;
            end
          end
        end
        ICACHE_MISS: begin
          if (mc_valid) begin
            // The request drops on the same edge that takes the word. The controller
            // stalls two cycles before it samples again, so no second fetch is issued.
            mc_fet_ena <= FALSE;
            state      <= ICACHE_IDLE;
            discard    <= FALSE;
            if (!discard && !flush) begin
              if_valid <= TRUE;
              if_instr <= mc_data;
            end
          end else if (flush) begin
            discard <= TRUE;
          end
        end
        default: state <= ICACHE_IDLE;
      endcase
    end
  end

endmodule
